// File: rtl/vga_wbm_arb.sv
// Wishbone master arbiter for the VGA core: video fetch vs CLUT loader.
// Grants only at burst boundaries and runs linear incrementing read bursts.
module vga_wbm_arb #(
    parameter int MAX_CONSEC = 4
) (
    input  logic        wb_clk_i,
    input  logic        arst_i,
    input  logic        ctrl_ven_i,
    input  logic        vid_req_i,
    input  logic [29:0] vid_adr_i,
    input  logic [3:0]  vid_len_i,
    output logic        vid_gnt_o,
    output logic        vid_dvld_o,
    output logic        vid_done_o,
    output logic        vid_err_o,
    input  logic        clut_req_i,
    input  logic [29:0] clut_adr_i,
    input  logic [3:0]  clut_len_i,
    output logic        clut_gnt_o,
    output logic        clut_dvld_o,
    output logic        clut_done_o,
    output logic        clut_err_o,
    output logic [31:0] dat_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_adr_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i
);
    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_EOB = 3'b111;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t      r_state, w_state_nxt;
    logic [CW-1:0] r_starve;
    logic        r_own;          // 0 = video, 1 = CLUT
    logic [3:0]  r_cnt;
    logic [31:0] r_adr, r_dat;
    logic [2:0]  r_cti;
    logic        r_cyc;
    logic        r_vid_gnt, r_vid_dvld, r_vid_done, r_vid_err;
    logic        r_clut_gnt, r_clut_dvld, r_clut_done, r_clut_err;
    logic        w_vid_elig, w_gnt_vid, w_gnt_clut, w_last_ack;

    assign w_vid_elig = vid_req_i & ctrl_ven_i;
    assign w_last_ack = wbm_ack_i & ~wbm_err_i & (r_cnt == 4'd0);

    always_comb begin
        w_gnt_vid   = 1'b0;
        w_gnt_clut  = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_vid_elig && clut_req_i && r_starve == CW'(MAX_CONSEC))
                    w_gnt_clut = 1'b1;
                else if (w_vid_elig)
                    w_gnt_vid = 1'b1;
                else if (clut_req_i)
                    w_gnt_clut = 1'b1;
                if (w_gnt_vid || w_gnt_clut)
                    w_state_nxt = S_BURST;
            end
            S_BURST: begin
                if (wbm_err_i || w_last_ack)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_starve    <= '0;
            r_own       <= 1'b0;
            r_cnt       <= 4'd0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_cti       <= 3'b000;
            r_cyc       <= 1'b0;
            r_vid_gnt   <= 1'b0;
            r_vid_dvld  <= 1'b0;
            r_vid_done  <= 1'b0;
            r_vid_err   <= 1'b0;
            r_clut_gnt  <= 1'b0;
            r_clut_dvld <= 1'b0;
            r_clut_done <= 1'b0;
            r_clut_err  <= 1'b0;
        end else begin
            r_vid_gnt   <= w_gnt_vid;
            r_clut_gnt  <= w_gnt_clut;
            r_vid_dvld  <= 1'b0;
            r_vid_done  <= 1'b0;
            r_vid_err   <= 1'b0;
            r_clut_dvld <= 1'b0;
            r_clut_done <= 1'b0;
            r_clut_err  <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_gnt_vid || w_gnt_clut) begin
                    r_own <= w_gnt_clut;
                    r_adr <= w_gnt_clut ? {clut_adr_i, 2'b00} : {vid_adr_i, 2'b00};
                    r_cnt <= w_gnt_clut ? clut_len_i : vid_len_i;
                    r_cti <= ((w_gnt_clut ? clut_len_i : vid_len_i) == 4'd0) ? CTI_EOB : CTI_INC;
                    r_cyc <= 1'b1;
                end
                // Only video grants taken while the CLUT waits count toward starvation.
                if (w_gnt_clut)
                    r_starve <= '0;
                else if (w_gnt_vid) begin
                    if (!clut_req_i)
                        r_starve <= '0;
                    else if (r_starve != CW'(MAX_CONSEC))
                        r_starve <= r_starve + 1'b1;
                end
            end else begin
                if (wbm_err_i) begin
                    r_cyc       <= 1'b0;
                    r_cti       <= 3'b000;
                    r_vid_err   <= ~r_own;
                    r_vid_done  <= ~r_own;
                    r_clut_err  <= r_own;
                    r_clut_done <= r_own;
                end else if (wbm_ack_i) begin
                    r_adr       <= r_adr + 32'd4;
                    r_dat       <= wbm_dat_i;
                    r_vid_dvld  <= ~r_own;
                    r_clut_dvld <= r_own;
                    if (r_cnt == 4'd0) begin
                        r_cyc       <= 1'b0;
                        r_cti       <= 3'b000;
                        r_vid_done  <= ~r_own;
                        r_clut_done <= r_own;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        r_cti <= (r_cnt == 4'd1) ? CTI_EOB : CTI_INC;
                    end
                end
            end
        end
    end

    assign vid_gnt_o   = r_vid_gnt;
    assign vid_dvld_o  = r_vid_dvld;
    assign vid_done_o  = r_vid_done;
    assign vid_err_o   = r_vid_err;
    assign clut_gnt_o  = r_clut_gnt;
    assign clut_dvld_o = r_clut_dvld;
    assign clut_done_o = r_clut_done;
    assign clut_err_o  = r_clut_err;
    assign dat_o       = r_dat;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_adr_o   = r_adr;
    assign wbm_cti_o   = r_cti;
    assign wbm_bte_o   = 2'b00;
    assign wbm_we_o    = 1'b0;
    assign wbm_sel_o   = 4'hf;

endmodule

// File: tb/tb_vga_wbm_arb.sv
// Bench for vga_wbm_arb: table of bursts plus arbitration/reset sequences,
// with a behavioural slave and per-requester data scoreboards.
module tb_vga_wbm_arb;
    logic        wb_clk_i = 1'b0;
    logic        arst_i, ctrl_ven_i;
    logic        vid_req_i, clut_req_i;
    logic [29:0] vid_adr_i, clut_adr_i;
    logic [3:0]  vid_len_i, clut_len_i;
    logic        vid_gnt_o, vid_dvld_o, vid_done_o, vid_err_o;
    logic        clut_gnt_o, clut_dvld_o, clut_done_o, clut_err_o;
    logic [31:0] dat_o, wbm_adr_o, wbm_dat_i;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [3:0]  wbm_sel_o;

    vga_wbm_arb #(.MAX_CONSEC(4)) dut (
        .wb_clk_i(wb_clk_i), .arst_i(arst_i), .ctrl_ven_i(ctrl_ven_i),
        .vid_req_i(vid_req_i), .vid_adr_i(vid_adr_i), .vid_len_i(vid_len_i),
        .vid_gnt_o(vid_gnt_o), .vid_dvld_o(vid_dvld_o), .vid_done_o(vid_done_o), .vid_err_o(vid_err_o),
        .clut_req_i(clut_req_i), .clut_adr_i(clut_adr_i), .clut_len_i(clut_len_i),
        .clut_gnt_o(clut_gnt_o), .clut_dvld_o(clut_dvld_o), .clut_done_o(clut_done_o), .clut_err_o(clut_err_o),
        .dat_o(dat_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    localparam logic [31:0] DK = 32'h5A3C_0000;

    typedef struct {
        bit          own;       // 0 video, 1 CLUT
        logic [29:0] adr;
        logic [3:0]  len;
        int          waits;
        int          err_beat;  // -1: no error
        int          exp_dv;
        bit          exp_err;
    } vec_t;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] vid_q[$], clut_q[$];
    bit          cur_own, hold_req, done_seen, err_seen;
    logic [31:0] exp_adr;
    int          beats_left, dv_cnt, gnt_cyc, done_cyc, cyc_n;
    int          slv_wait, slv_err_beat, slv_wcnt, slv_beat;
    bit          gnt_hist[10];
    int          n_gnt;
    vec_t        vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // One clock: observe outputs at negedge, update the model, then drive the slave.
    task automatic step();
        logic [29:0] a;
        logic [3:0]  l;
        @(negedge wb_clk_i);
        cyc_n++;
        chk("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
        if (vid_gnt_o || clut_gnt_o) begin
            chk("gnt_onehot", vid_gnt_o & clut_gnt_o, 0);
            cur_own    = clut_gnt_o;
            a          = cur_own ? clut_adr_i : vid_adr_i;
            l          = cur_own ? clut_len_i : vid_len_i;
            exp_adr    = {a, 2'b00};
            beats_left = int'(l) + 1;
            dv_cnt     = 0;
            gnt_cyc    = cyc_n;
            for (int k = 0; k <= int'(l); k++) begin
                if (cur_own) clut_q.push_back((exp_adr + 32'(4 * k)) ^ DK);
                else         vid_q.push_back((exp_adr + 32'(4 * k)) ^ DK);
            end
            if (n_gnt < 10) gnt_hist[n_gnt] = cur_own;
            n_gnt++;
            if (!hold_req) begin
                if (cur_own) clut_req_i = 1'b0;
                else         vid_req_i  = 1'b0;
            end
        end
        if (wbm_cyc_o) begin
            chk("adr", wbm_adr_o, exp_adr);
            chk("cti", 32'(wbm_cti_o), (beats_left == 1) ? 32'd7 : 32'd2);
        end
        if (vid_dvld_o) begin
            dv_cnt++;
            chk("vid_dvld_owner", 32'(cur_own), 0);
            if (vid_q.size() == 0) chk("vid_q_underflow", 1, 0);
            else                   chk("vid_dat", dat_o, vid_q.pop_front());
        end
        if (clut_dvld_o) begin
            dv_cnt++;
            chk("clut_dvld_owner", 32'(cur_own), 1);
            if (clut_q.size() == 0) chk("clut_q_underflow", 1, 0);
            else                    chk("clut_dat", dat_o, clut_q.pop_front());
        end
        if (vid_done_o || clut_done_o) begin
            done_seen = 1'b1;
            done_cyc  = cyc_n;
            err_seen  = vid_err_o | clut_err_o;
            chk("done_owner", 32'(clut_done_o), 32'(cur_own));
            chk("cyc_low_at_done", wbm_cyc_o, 0);
            if (err_seen) begin
                vid_q.delete();
                clut_q.delete();
            end else begin
                chk("q_empty_at_done", vid_q.size() + clut_q.size(), 0);
            end
        end
        if (wbm_cyc_o && arst_i) begin
            if (slv_wcnt >= slv_wait) begin
                slv_wcnt  = 0;
                wbm_ack_i = 1'b1;
                wbm_dat_i = wbm_adr_o ^ DK;
                if (slv_beat == slv_err_beat) begin
                    wbm_err_i = 1'b1;   // ack raised too: err must win
                end else begin
                    wbm_err_i = 1'b0;
                    exp_adr   = exp_adr + 32'd4;
                    beats_left--;
                end
                slv_beat++;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
                slv_wcnt++;
            end
        end else begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            slv_wcnt  = 0;
            slv_beat  = 0;
        end
    endtask

    task automatic run_burst(input int budget);
        int n;
        n = 0;
        done_seen = 1'b0;
        while (!done_seen && n < budget) begin
            step();
            n++;
        end
        if (!done_seen) chk("burst_timeout", 1, 0);
    endtask

    initial begin
        arst_i = 1'b0; ctrl_ven_i = 1'b1;
        vid_req_i = 1'b0; vid_adr_i = '0; vid_len_i = '0;
        clut_req_i = 1'b0; clut_adr_i = '0; clut_len_i = '0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
        hold_req = 1'b0; slv_wait = 0; slv_err_beat = -1; slv_wcnt = 0; slv_beat = 0;
        cyc_n = 0; n_gnt = 0; beats_left = 0; dv_cnt = 0; exp_adr = '0;

        vecs[0] = '{1'b0, 30'h100,        4'd3,  0, -1, 4,  1'b0};
        vecs[1] = '{1'b1, 30'h200,        4'd7,  0,  1, 1,  1'b1};
        vecs[2] = '{1'b0, 30'h3FFF_FFFF,  4'd2,  1, -1, 3,  1'b0};
        vecs[3] = '{1'b1, 30'h0ABC,       4'd0,  2, -1, 1,  1'b0};
        vecs[4] = '{1'b0, 30'h1234,       4'd15, 0, -1, 16, 1'b0};

        step(); step();
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_cti", 32'(wbm_cti_o), 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_pulses", {vid_gnt_o, vid_dvld_o, vid_done_o, vid_err_o,
                           clut_gnt_o, clut_dvld_o, clut_done_o, clut_err_o}, 0);
        chk("const_bus", {wbm_bte_o, wbm_we_o, wbm_sel_o}, 32'h0f);
        arst_i = 1'b1;
        step();

        foreach (vecs[i]) begin
            int nb;
            slv_wait = vecs[i].waits;
            slv_err_beat = vecs[i].err_beat;
            if (vecs[i].own) begin
                clut_adr_i = vecs[i].adr; clut_len_i = vecs[i].len; clut_req_i = 1'b1;
            end else begin
                vid_adr_i = vecs[i].adr; vid_len_i = vecs[i].len; vid_req_i = 1'b1;
            end
            step();
            chk("gnt_latency", vecs[i].own ? clut_gnt_o : vid_gnt_o, 1);
            run_burst(400);
            nb = vecs[i].exp_err ? vecs[i].err_beat + 1 : int'(vecs[i].len) + 1;
            chk("dvld_count", dv_cnt, vecs[i].exp_dv);
            chk("err_flag", 32'(err_seen), 32'(vecs[i].exp_err));
            chk("done_latency", done_cyc - gnt_cyc, nb * (vecs[i].waits + 1));
            step();
        end
        slv_wait = 0; slv_err_beat = -1;

        // Both requesting continuously: V V V V C repeated.
        hold_req = 1'b1; n_gnt = 0;
        vid_adr_i = 30'h400; vid_len_i = 4'd1; clut_adr_i = 30'h800; clut_len_i = 4'd0;
        vid_req_i = 1'b1; clut_req_i = 1'b1;
        for (int n = 0; n < 400 && n_gnt < 10; n++) step();
        hold_req = 1'b0; vid_req_i = 1'b0; clut_req_i = 1'b0;
        chk("prio_grant_count", n_gnt, 10);
        for (int g = 0; g < 10; g++) chk($sformatf("prio_order_%0d", g), 32'(gnt_hist[g]), (g == 4 || g == 9) ? 1 : 0);
        repeat (6) step();

        // Video disabled: CLUT only.
        hold_req = 1'b1; n_gnt = 0; ctrl_ven_i = 1'b0;
        vid_req_i = 1'b1; clut_req_i = 1'b1;
        for (int n = 0; n < 200 && n_gnt < 3; n++) step();
        hold_req = 1'b0; vid_req_i = 1'b0; clut_req_i = 1'b0;
        for (int g = 0; g < 3; g++) chk($sformatf("ven0_grant_%0d", g), 32'(gnt_hist[g]), 1);
        repeat (6) step();

        // Video enable dropped mid-burst: burst still completes.
        ctrl_ven_i = 1'b1; vid_adr_i = 30'h2000; vid_len_i = 4'd7; vid_req_i = 1'b1;
        step();
        chk("ven_drop_gnt", vid_gnt_o, 1);
        step(); step();
        ctrl_ven_i = 1'b0;
        run_burst(100);
        chk("ven_drop_dvld", dv_cnt, 8);
        chk("ven_drop_err", 32'(err_seen), 0);
        ctrl_ven_i = 1'b1;
        step();

        // Asynchronous reset mid-burst, then a pending CLUT request.
        vid_adr_i = 30'h3000; vid_len_i = 4'd7; vid_req_i = 1'b1;
        step();
        step(); step(); step();
        #1 arst_i = 1'b0;
        #1;
        chk("arst_cyc", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("arst_adr", wbm_adr_o, 0);
        chk("arst_cti", 32'(wbm_cti_o), 0);
        chk("arst_dat", dat_o, 0);
        chk("arst_pulses", {vid_gnt_o, vid_dvld_o, vid_done_o, vid_err_o,
                            clut_gnt_o, clut_dvld_o, clut_done_o, clut_err_o}, 0);
        vid_q.delete(); clut_q.delete();
        clut_adr_i = 30'h40; clut_len_i = 4'd1; clut_req_i = 1'b1;
        step();
        arst_i = 1'b1;
        step();
        chk("post_rst_gnt", clut_gnt_o, 1);
        run_burst(50);
        chk("post_rst_dvld", dv_cnt, 2);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
